// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - instruction memory read port and decode handshake bundle
interface imem_fetch_ctrl_if;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;

  modport master (
    output imem_pc,
    input  imem_instr,
    output if_valid,
    output if_instr,
    output if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_pc,
    output imem_instr,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output if_ready
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - fetch PC sequencer with prefetch queue, redirect and range check
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          IMEM_WORDS  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_fetch_ctrl_if.master    bus,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 addr_err
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] WORDS_LIMIT = 32'(IMEM_WORDS);

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      pc_q    [QUEUE_DEPTH];
  logic [31:0]      instr_q [QUEUE_DEPTH];

  logic in_range;
  logic pop;
  logic room;
  logic push;

  always_comb begin
    in_range = (fetch_pc >> 2) < WORDS_LIMIT;
    pop      = bus.if_valid & bus.if_ready;
    room     = (count < CNT_W'(QUEUE_DEPTH)) | pop;
    push     = fetch_en & in_range & room & ~redirect_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      addr_err <= 1'b0;
    end else if (redirect_valid) begin
      // A head offered alongside a redirect is squashed, never consumed.
      fetch_pc <= redirect_pc & ~32'h3;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      addr_err <= 1'b0;
    end else begin
      if (push) begin
        tail     <= tail + PTR_W'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (fetch_en && !in_range) begin
        addr_err <= 1'b1;
      end
    end
  end

  // Storage needs no reset: empty entries are masked on the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail]    <= fetch_pc;
      instr_q[tail] <= bus.imem_instr;
    end
  end

  always_comb begin
    bus.imem_pc  = fetch_pc;
    bus.if_valid = (count != '0);
    bus.if_pc    = bus.if_valid ? pc_q[head]    : 32'h0;
    bus.if_instr = bus.if_valid ? instr_q[head] : 32'h0;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer for the 256-word instruction memory.
- Owns the fetch PC and drives the memory's word-addressed read port; the read data returns combinationally in the same cycle.
- Captures each {pc, instruction} pair into a small prefetch queue and hands entries to decode over a valid/ready handshake.
- Handles branch/jump redirects (queue flush plus PC reload), decode backpressure, fetch halt and out-of-range fetch detection.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded at reset.
QUEUE_DEPTH, 2, prefetch queue entries; power of two, 2..8.
IMEM_WORDS, 256, instruction memory size in 32-bit words; defines the legal fetch range.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
imem_pc  out  32  byte address to instruction memory PC input; equals fetch_pc register.
imem_instr  in  32  instruction memory data, combinational from imem_pc.
fetch_en  in  1  1 = fetch allowed; 0 = hold fetch_pc, no push.
redirect_valid  in  1  branch/jump taken this cycle.
redirect_pc  in  32  redirect target byte address.
if_valid  out  1  queue head valid.
if_instr  out  32  queue head instruction.
if_pc  out  32  queue head byte address.
if_ready  in  1  decode accepts head this cycle.
addr_err  out  1  sticky out-of-range fetch flag.

Behaviour:
- Reset (rst_n=0, any time, asynchronous):
  - fetch_pc=RESET_PC; queue emptied.
  - if_valid=0, if_instr=0, if_pc=0, addr_err=0.
  - Queue contents are discarded.
- Derived signals:
  - in_range = (fetch_pc>>2) < IMEM_WORDS.
  - pop = if_valid & if_ready.
  - room = (count<QUEUE_DEPTH) | pop.
  - push = fetch_en & in_range & room & ~redirect_valid.
- On a push edge:
  - Enqueue {fetch_pc, imem_instr} at the tail.
  - fetch_pc += 4, with 32-bit modulo wrap.
- Simultaneous push and pop on a full queue is legal; count is unchanged.
- Redirect (redirect_valid=1 at an edge) has top priority:
  - Queue flushed, count=0.
  - fetch_pc = {redirect_pc[31:2],2'b00}; misaligned low bits are dropped silently.
  - No push or pop takes effect that edge; a head offered that cycle is treated as squashed, not consumed.
  - addr_err cleared.
  - If_valid is 0 for exactly one cycle after the redirect edge (fetch_en=1, target in range), then rises carrying the target.
- Out-of-range fetch: if fetch_pc is out of range while fetch_en=1:
  - No push; fetch_pc holds.
  - addr_err set at the edge and held until a redirect or reset.
  - Entries already queued still drain normally.
- fetch_en=0: fetch_pc and the push path freeze; pops continue.
- Outputs:
  - if_valid = (count!=0).
  - if_instr/if_pc = head entry when valid, 0 when empty (registered storage, muxed to 0 on empty).
- Latency: the first edge after reset release with fetch_en=1 pushes mem[RESET_PC>>2]; if_valid=1 after that edge.
- Steady state with if_ready=1: one instruction per cycle, consecutive if_pc values stepping by 4.
- Head/tail pointers are log2(QUEUE_DEPTH) bits, wrapping naturally. The count register is one bit wider to distinguish full from empty.
- No combinational path from if_ready to imem_pc.

Test Plan:
- Streaming: memory holds words 0x20080005, 0x20090003, ... at 0..; reset, fetch_en=1, if_ready=1 -> if_valid rises after edge 1; if_pc sequence 0,4,8,12 with matching instructions, one per cycle.
- Backpressure: if_ready=0 for 5 cycles -> queue fills to QUEUE_DEPTH=2, imem_pc stops at 0x8; head stays pc 0. Release -> pcs 0,4,8,12 with no gap or duplicate.
- Redirect with simultaneous pop: at the cycle head pc=0x8 is offered with if_ready=1, assert redirect_valid with redirect_pc=0x40 -> 0x8 is not consumed. If_valid=0 the next cycle, then if_pc=0x40, 0x44.
- Misaligned redirect: redirect_pc=0x43 -> next if_pc=0x40.
- Out-of-range: redirect to 0x3FC (word 255) -> entry 0x3FC delivered. Then fetch_pc=0x400: addr_err=1, no further if_valid, imem_pc holds 0x400. Redirect to 0x0 clears addr_err and fetching resumes.
- Async reset mid-stream: drop rst_n between edges with queue full -> if_valid, if_pc, addr_err go 0 immediately; imem_pc=RESET_PC. On release, fetch restarts at RESET_PC.
